soc_reset_seq: RTL and testbench



---
 rtl/soc_reset_seq.sv | 164 ++++++++++++++++
 tb/tb_soc_reset_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_reset_seq.sv
// soc_reset_seq: calib-gated, counted release of peripheral and core resets.
// Optional calibration watchdog: define RST_SEQ_CALIB_TIMEOUT_EN.
module soc_reset_seq #(
  parameter int unsigned HoldCycles    = 16,
  parameter int unsigned NdmHoldCycles = 8,
  parameter int unsigned CalibTimeout  = 1048576
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic calib_done_i,
  input  logic ndmreset_i,
  output logic periph_rst_no,
  output logic core_rst_no,
  output logic ready_o,
  output logic timeout_o
);

  localparam int unsigned MaxHn =
    (HoldCycles > NdmHoldCycles) ? HoldCycles : NdmHoldCycles;
  localparam int unsigned MaxCnt =
    (MaxHn > CalibTimeout) ? MaxHn : CalibTimeout;
  localparam int unsigned CntW =
    (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

  localparam logic [CntW-1:0] HoldLd = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] NdmLd  = CntW'(NdmHoldCycles - 1);

`ifdef RST_SEQ_CALIB_TIMEOUT_EN
  // Every entry to WAIT_CALIB (reset included) arms the watchdog.
  localparam logic [CntW-1:0] WaitLd = CntW'(CalibTimeout - 1);
`else
  localparam logic [CntW-1:0] WaitLd = '0;
`endif

  typedef enum logic [2:0] {
    WAIT_CALIB,
    HOLD_PERIPH,
    HOLD_CORE,
    RUN,
    NDM_HOLD,
    FAULT
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            calib_meta_q;
  logic            calib_s_q;
  logic            periph_q;
  logic            core_q;
  logic            ready_q;
  logic            lost;

`ifdef RST_SEQ_CALIB_TIMEOUT_EN
  logic            timeout_q;
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign periph_rst_no = periph_q;
  assign core_rst_no   = core_q;
  assign ready_o       = ready_q;

  assign lost = !calib_s_q &&
                (state_q != WAIT_CALIB) &&
                (state_q != FAULT);

  // Two-flop synchroniser for the asynchronous MIG calib flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      calib_meta_q <= 1'b0;
      calib_s_q    <= 1'b0;
    end else begin
      calib_meta_q <= calib_done_i;
      calib_s_q    <= calib_meta_q;
    end
  end

  // Sequencer FSM with registered reset outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= WAIT_CALIB;
      cnt_q     <= WaitLd;
      periph_q  <= 1'b0;
      core_q    <= 1'b0;
      ready_q   <= 1'b0;
`ifdef RST_SEQ_CALIB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else if (lost) begin
      state_q  <= WAIT_CALIB;
      cnt_q    <= WaitLd;
      periph_q <= 1'b0;
      core_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      unique case (state_q)
        WAIT_CALIB: begin
          if (calib_s_q) begin
            state_q <= HOLD_PERIPH;
            cnt_q   <= HoldLd;
`ifdef RST_SEQ_CALIB_TIMEOUT_EN
          end else if (cnt_q == '0) begin
            state_q   <= FAULT;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
`endif
          end
        end
        HOLD_PERIPH: begin
          if (cnt_q == '0) begin
            state_q  <= HOLD_CORE;
            cnt_q    <= HoldLd;
            periph_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        HOLD_CORE: begin
          if (cnt_q == '0) begin
            state_q <= RUN;
            core_q  <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        RUN: begin
          if (ndmreset_i) begin
            state_q <= NDM_HOLD;
            cnt_q   <= NdmLd;
            core_q  <= 1'b0;
            ready_q <= 1'b0;
          end
        end
        NDM_HOLD: begin
          if (ndmreset_i) begin
            cnt_q <= NdmLd;
          end else if (cnt_q == '0) begin
            state_q <= RUN;
            core_q  <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        FAULT: begin
          periph_q <= 1'b0;
          core_q   <= 1'b0;
          ready_q  <= 1'b0;
        end
        default: begin
          state_q  <= WAIT_CALIB;
          cnt_q    <= WaitLd;
          periph_q <= 1'b0;
          core_q   <= 1'b0;
          ready_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soc_reset_seq.sv
// tb_soc_reset_seq: directed release/ndm/drop/reset cases plus random
// calib/ndm traffic against a lock-age based reference model.
module tb_soc_reset_seq;

  localparam int H   = 4;
  localparam int NDM = 8;
  localparam int CT  = 100;
  localparam int NONE = -1000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic calib = 1'b0;
  logic ndm = 1'b0;
  logic periph_n, core_n, ready, tmo;

  int n_chk = 0;
  int n_err = 0;

  // model: calib history, lock age, last accepted ndm edge
  bit h0, h1;
  int run_len;
  int ndm_last;
  int wcnt;
  bit fault;
  int edge_n;

  soc_reset_seq #(
    .HoldCycles   (H),
    .NdmHoldCycles(NDM),
    .CalibTimeout (CT)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .calib_done_i (calib),
    .ndmreset_i   (ndm),
    .periph_rst_no(periph_n),
    .core_rst_no  (core_n),
    .ready_o      (ready),
    .timeout_o    (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    h0 = 0;
    h1 = 0;
    run_len = 0;
    ndm_last = NONE;
    wcnt = 0;
    fault = 0;
  endtask

  // Lock age = consecutive edges seeing synchronised calib high.
  task automatic model_edge();
    bit c2;
    int prev;
    c2 = h1;
    h1 = h0;
    h0 = calib;
    prev = run_len;
    if (fault) begin
    end else if (!c2) begin
      if (prev > 0) begin
        wcnt = 0;
      end else begin
`ifdef RST_SEQ_CALIB_TIMEOUT_EN
        wcnt++;
        if (wcnt >= CT) fault = 1;
`endif
      end
      run_len = 0;
      ndm_last = NONE;
    end else begin
      if (prev >= 2*H+1 && ndm) ndm_last = edge_n;
      run_len++;
    end
  endtask

  task automatic step();
    bit ep, ec;
    @(posedge clk);
    model_edge();
    #1;
    ep = !fault && run_len >= H+1;
    ec = !fault && run_len >= 2*H+1 &&
         (edge_n - ndm_last) >= NDM;
    chk("periph", periph_n, ep);
    chk("core", core_n, ec);
    chk("ready", ready, ec);
    chk("timeout", tmo, fault);
    edge_n++;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_periph", periph_n, 0);
    chk("rst_core", core_n, 0);
    chk("rst_ready", ready, 0);
    chk("rst_tmo", tmo, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic measure(input int lim,
                         output int p_r, output int c_r);
    p_r = -1;
    c_r = -1;
    for (int k = 0; k < lim; k++) begin
      step();
      if (periph_n && p_r < 0) p_r = k;
      if (core_n && c_r < 0) c_r = k;
    end
  endtask

  task automatic ndm_pulse(input int rep, output int rise,
                           output int pmin);
    rise = -1;
    pmin = 1;
    for (int k = 0; k < 30; k++) begin
      ndm = (k == 0 || k == rep);
      step();
      if (k == 0) chk("core_at_N", core_n, 0);
      if (!periph_n) pmin = 0;
      if (k > 0 && core_n && rise < 0) rise = k;
    end
    ndm = 1'b0;
  endtask

  initial begin
    int pr, cr, pm, fall, t;
    int low_left, ndm_left;
    edge_n = 0;
    model_reset();

    do_reset();
    calib = 1'b1;
    measure(16, pr, cr);
    chk("periph_rel", pr, 6);
    chk("core_rel", cr, 10);

    ndm_pulse(-1, cr, pm);
    chk("ndm_rise", cr, 8);
    chk("ndm_periph", pm, 1);

    ndm_pulse(5, cr, pm);
    chk("ndm_rep_rise", cr, 13);
    chk("ndm_rep_periph", pm, 1);

    fall = -1;
    for (int k = 0; k < 12; k++) begin
      ndm = (k == 0);
      if (k == 3) calib = 1'b0;
      step();
      if (!periph_n && fall < 0) fall = k;
    end
    ndm = 1'b0;
    chk("drop_fall", fall, 5);
    calib = 1'b1;
    measure(16, pr, cr);
    chk("relock_periph", pr, 6);
    chk("relock_core", cr, 10);

    calib = 1'b0;
    repeat (4) step();
    calib = 1'b1;
    repeat (8) step();
    chk("pre_rst_periph", periph_n, 1);
    calib = 1'b0;
    do_reset();
    cr = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (core_n) cr = 1;
    end
    chk("no_core_wo_calib", cr, 0);
    calib = 1'b1;
    measure(16, pr, cr);
    chk("rst_relock_periph", pr, 6);
    chk("rst_relock_core", cr, 10);

    low_left = 0;
    ndm_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (low_left > 0) begin
        calib = 1'b0;
        low_left--;
      end else begin
        calib = 1'b1;
        if ($urandom_range(0, 299) == 0)
          low_left = $urandom_range(1, 8);
      end
      if (ndm_left > 0) begin
        ndm = 1'b1;
        ndm_left--;
      end else begin
        ndm = 1'b0;
        if ($urandom_range(0, 19) == 0)
          ndm_left = $urandom_range(1, 12);
      end
      step();
    end
    ndm = 1'b0;

    calib = 1'b0;
    do_reset();
`ifdef RST_SEQ_CALIB_TIMEOUT_EN
    t = -1;
    for (int k = 1; k <= 150; k++) begin
      step();
      if (tmo && t < 0) t = k;
    end
    chk("timeout_edge", t, CT);
    calib = 1'b1;
    repeat (20) step();
    chk("fault_periph", periph_n, 0);
    chk("fault_core", core_n, 0);
`else
    t = 0;
    for (int k = 0; k < 10000; k++) begin
      step();
      if (tmo) t = 1;
    end
    chk("no_timeout", t, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
